alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 193 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result/flag stage and a persistent carry for ADC/SBB.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier behind opcode 4.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_err
);
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADC  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SBB  = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NAND = 5'd11;
    localparam logic [4:0] OP_NOR  = 5'd12;
    localparam logic [4:0] OP_XNOR = 5'd13;
    localparam logic [4:0] OP_NOT  = 5'd14;
    localparam logic [4:0] OP_NEG  = 5'd15;
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < 4 || CNT_W != $clog2(WIDTH + 1)) begin : g_param_check
        $error("alu_pipe: WIDTH must be >= 4 and CNT_W must stay derived from WIDTH");
    end

    logic             c_q;
    logic             busy;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_ovf;
    logic             res_err;
    logic             upd_c;

`ifdef ALU_PIPE_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd4;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             mul_done;

    assign busy     = (state == S_MUL);
    assign acc_nxt  = mplier[0] ? acc + mcand : acc;
    assign mul_done = busy && (cnt == CNT_W'(WIDTH - 1));
`else
    assign busy = 1'b0;
`endif

    assign in_ready = !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Subtraction and negation share the single adder through operand inversion.
    always_comb begin
        opa = a;
        opb = b;
        cin = 1'b0;
        case (opcode)
            OP_ADC: cin = c_q;
            OP_SUB: begin opb = ~b; cin = 1'b1; end
            OP_SBB: begin opb = ~b; cin = c_q; end
            OP_NEG: begin opa = ~a; opb = '0; cin = 1'b1; end
            default: ;
        endcase
    end

    assign sum = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};

    always_comb begin
        res     = '0;
        res_c   = c_q;
        res_ovf = 1'b0;
        res_err = 1'b0;
        upd_c   = 1'b0;
        is_mul  = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                res     = sum[WIDTH-1:0];
                res_c   = sum[WIDTH];
                upd_c   = 1'b1;
                res_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_NEG: begin
                res     = sum[WIDTH-1:0];
                res_c   = sum[WIDTH];
                upd_c   = 1'b1;
                res_ovf = (a == SMIN);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_XNOR: res = ~(a ^ b);
            OP_NOT:  res = ~a;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: res_err = 1'b1;
        endcase
    end

    // Result register stage: single-cycle ops land here one edge after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
            c_q       <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            out       <= res;
            out_carry <= res_c;
            out_zero  <= (res == '0);
            out_ovf   <= res_ovf;
            out_err   <= res_err;
            if (upd_c) begin
                c_q <= res_c;
            end
`ifdef ALU_PIPE_MUL_EN
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out       <= acc_nxt;
            out_carry <= c_q;
            out_zero  <= (acc_nxt == '0);
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_PIPE_MUL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (accept && is_mul) begin
                state <= S_MUL;
                cnt   <= '0;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (mul_done) begin
                state <= S_IDLE;
            end
        end
    end

    // Multiplier datapath: one shift-add step per cycle while busy.
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed test-plan cases plus randomized traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_alu_pipe;
    localparam int W = 32;
    localparam logic [4:0] ADD = 5'd0, ADC = 5'd1, SUB = 5'd2, SBB = 5'd3, MUL = 5'd4;
    localparam logic [4:0] AND_ = 5'd8, OR_ = 5'd9, XOR_ = 5'd10, XNOR_ = 5'd13, NEG = 5'd15;
    localparam longint TWO_W = 64'sh1_0000_0000;
    localparam longint SMAX  = 64'sh7FFF_FFFF;
    localparam longint SMINL = -64'sh8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   opcode;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_carry;
    logic         out_zero;
    logic         out_ovf;
    logic         out_err;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .a(a_i), .b(b_i), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .out_carry(out_carry), .out_zero(out_zero), .out_ovf(out_ovf), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic c, z, v, e;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] seen_o[$];
    int           seen_cyc[$];
    logic         m_c = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    bit           rnd_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic res_t model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t   r;
        longint ux, uy, sx, sy, s, k;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y);
        r.o = '0; r.c = m_c; r.v = 1'b0; r.e = 1'b0;
        case (op)
            ADD, ADC: begin
                k = (op == ADC) ? longint'(m_c) : 0;
                s = ux + uy + k;
                r.o = s[W-1:0];
                r.c = (s >= TWO_W);
                r.v = (sx + sy + k > SMAX) || (sx + sy + k < SMINL);
                m_c = r.c;
            end
            SUB, SBB: begin
                k = (op == SBB) ? 1 - longint'(m_c) : 0;
                s = ux - uy - k;
                r.o = s[W-1:0];
                r.c = (ux >= uy + k);
                r.v = (sx - sy - k > SMAX) || (sx - sy - k < SMINL);
                m_c = r.c;
            end
            NEG: begin
                s = -ux;
                r.o = s[W-1:0];
                r.c = (x == '0);
                r.v = (x == 32'h8000_0000);
                m_c = r.c;
            end
`ifdef ALU_PIPE_MUL_EN
            MUL: begin
                s = ux * uy;
                r.o = s[W-1:0];
            end
`endif
            AND_:   r.o = x & y;
            OR_:    r.o = x | y;
            XOR_:   r.o = x ^ y;
            5'd11:  r.o = ~(x & y);
            5'd12:  r.o = ~(x | y);
            XNOR_:  r.o = ~(x ^ y);
            5'd14:  r.o = ~x;
            default: r.e = 1'b1;
        endcase
        r.z = (r.o == '0);
        return r;
    endfunction

    // Scoreboard: check every consumed result, then log newly accepted operations.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_c = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("sb.spurious_valid", out_valid, 1'b0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("sb.out", out, e.o);
                    chk1("sb.carry", out_carry, e.c);
                    chk1("sb.zero", out_zero, e.z);
                    chk1("sb.ovf", out_ovf, e.v);
                    chk1("sb.err", out_err, e.e);
                    seen_o.push_back(out);
                    seen_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(opcode, a_i, b_i));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic got;
        got = 1'b0;
        in_valid = 1'b1; opcode = op; a_i = x; b_i = y;
        for (int g = 0; g < 300 && !got; g++) begin
            @(negedge clk);
            got = in_ready;
            sync();
        end
        in_valid = 1'b0;
        chk1("send.accepted", got, 1'b1);
    endtask

    task automatic expect1(input string nm, input logic [W-1:0] eo,
                           input logic ec, input logic ez, input logic ev, input logic ee);
        @(negedge clk);
        chk1({nm, ".valid"}, out_valid, 1'b1);
        chk({nm, ".out"}, out, eo);
        chk1({nm, ".carry"}, out_carry, ec);
        chk1({nm, ".zero"}, out_zero, ez);
        chk1({nm, ".ovf"}, out_ovf, ev);
        chk1({nm, ".err"}, out_err, ee);
        sync();
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] legal[13];
        int         k, n;
        legal = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk1("reset.out_valid", out_valid, 1'b0);
        chk("reset.out", out, '0);
        chk1("reset.carry", out_carry, 1'b0);
        chk1("reset.zero", out_zero, 1'b0);
        chk1("reset.ovf", out_ovf, 1'b0);
        chk1("reset.err", out_err, 1'b0);
        chk1("reset.in_ready", in_ready, 1'b1);
        sync();

        send(ADD, 32'hFFFF_FFFF, 32'h1);        expect1("add_wrap", 32'h0, 1, 1, 0, 0);
        send(ADC, 32'h0, 32'h0);                expect1("adc_cin", 32'h1, 0, 0, 0, 0);
        send(SUB, 32'h5, 32'h7);                expect1("sub_borrow", 32'hFFFF_FFFE, 0, 0, 0, 0);
        send(SUB, 32'h8000_0000, 32'h1);        expect1("sub_ovf", 32'h7FFF_FFFF, 1, 0, 1, 0);
        send(NEG, 32'h8000_0000, 32'h0);        expect1("neg_min", 32'h8000_0000, 0, 0, 1, 0);
        send(ADD, 32'hFFFF_FFFF, 32'h1);        expect1("add_setc", 32'h0, 1, 1, 0, 0);
        send(5'd6, 32'h1234, 32'h5678);         expect1("illegal6", 32'h0, 1, 1, 0, 1);
        send(ADC, 32'h0, 32'h0);                expect1("c_kept", 32'h1, 0, 0, 0, 0);
        send(ADD, 32'hFFFF_FFFF, 32'h1);        expect1("add_setc2", 32'h0, 1, 1, 0, 0);

`ifdef ALU_PIPE_MUL_EN
        send(MUL, 32'h0001_0003, 32'h10);
        k = 0;
        for (int g = 0; g < 60; g++) begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            chk1("mul.in_ready_low", in_ready, 1'b0);
        end
        chk("mul.latency_edges", W'(k - 1), W'(W));
        chk("mul.out", out, 32'h0010_0030);
        chk1("mul.carry", out_carry, 1'b1);
        chk1("mul.ovf", out_ovf, 1'b0);
        chk1("mul.err", out_err, 1'b0);
        sync();
`else
        send(MUL, 32'h0001_0003, 32'h10);       expect1("mul_off", 32'h0, 1, 1, 0, 1);
`endif

        out_ready = 1'b0;
        send(AND_, 32'hF0F0_F0F0, 32'hFF00_FF00);
        in_valid = 1'b1; opcode = OR_;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold.out", out, 32'hF000_F000);
            chk1("hold.valid", out_valid, 1'b1);
            chk1("hold.in_ready", in_ready, 1'b0);
            sync();
        end
        out_ready = 1'b1;
        send(OR_, 32'hF0F0_F0F0, 32'hFF00_FF00);
        send(XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00);
        send(XNOR_, 32'hF0F0_F0F0, 32'hFF00_FF00);
        sync();
        sync();
        n = seen_o.size();
        if (n >= 4) begin
            chk("b2b.first", seen_o[n-4], 32'hF000_F000);
            chk("b2b.second", seen_o[n-3], 32'hFFF0_FFF0);
            chk("b2b.third", seen_o[n-2], 32'h0FF0_0FF0);
            chk("b2b.fourth", seen_o[n-1], 32'hF00F_F00F);
            chk("b2b.no_bubble", W'(seen_cyc[n-1] - seen_cyc[n-4]), W'(3));
        end else begin
            chk("b2b.count", W'(n), W'(4));
        end

        send(ADD, 32'hFFFF_FFFF, 32'h1);        expect1("pre_rst_c", 32'h0, 1, 1, 0, 0);
        send(MUL, 32'h1234_5678, 32'h09AB_CDEF);
        repeat (9) sync();
        rst = 1'b1;
        sync();
        sync();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rst.out_valid", out_valid, 1'b0);
            chk1("rst.in_ready", in_ready, 1'b1);
            sync();
        end
        send(ADC, 32'h0, 32'h0);                expect1("rst_c_cleared", 32'h0, 0, 1, 0, 0);
        send(ADD, 32'h2, 32'h3);                expect1("post_rst_add", 32'h5, 0, 0, 0, 0);

        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : legal[$urandom_range(0, 12)];
            send(op, rnd_val(), rnd_val());
            if ($urandom_range(0, 3) == 0) sync();
        end
        rnd_rdy = 0;
        out_ready = 1'b1;
        for (int g = 0; g < 100 && exp_q.size() != 0; g++) sync();
        chk("drain.pending", W'(exp_q.size()), W'(0));
        @(negedge clk);
        chk1("drain.out_valid", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
